wb_slave_mem: RTL and testbench
===============================

// Module: wb_slave_mem
// PURPOSE
// Wishbone classic (B3) 64-bit slave memory that consumes the cycles driven
// by the VGA/LCD Wishbone master port. It is the frame/CLUT memory model
// behind that port in the SoC and the unit bench.
// Supports byte-lane writes, configurable wait states, ERR on out-of-range
// addresses, and deterministic RTY injection.
// PARAMETERS
// DEPTH        256  number of 64-bit words; valid word index 0..DEPTH-1
// WAIT_STATES  1    idle cycles between request sample and response (0..15)
// RTY_EVERY    0    every Nth accepted request gets RTY_O; 0 disables retry
// PORTS
// clk     in   1   clock; all state updates on the rising edge
// rst     in   1   asynchronous, active-low reset
// ADR_I   in   64  byte address; word index = ADR_I[63:3], ADR_I[2:0] ignored
// DAT_I   in   64  write data
// SEL_I   in   8   byte enables; SEL_I[k] selects DAT_I[8k+7:8k]
// CYC_I   in   1   bus cycle valid
// STB_I   in   1   strobe, request valid
// WE_I    in   1   1 = write, 0 = read
// LOCK_I  in   1   accepted and ignored
// TGA_I   in   16  address tag, captured at request sample
// TGD_I   in   16  data tag, ignored
// DAT_O   out  64  read data; valid only while ACK_O=1, else 0
// TGD_O   out  16  echoes the captured TGA_I while ACK_O=1, else 0
// ACK_O   out  1   normal termination, one-cycle pulse
// ERR_O   out  1   error termination, one-cycle pulse
// RTY_O   out  1   retry termination, one-cycle pulse
// BEHAVIOUR
// Reset (rst=0, asynchronous):
// - ACK_O, ERR_O and RTY_O go to 0. DAT_O and TGD_O go to 0.
// - FSM goes to IDLE. Wait counter and retry counter clear to 0.
// - Memory array is not reset; contents are preserved across reset.
// FSM states: IDLE, WAIT, RESP.
// - IDLE: on an edge with CYC_I & STB_I, capture ADR_I, WE_I, SEL_I, DAT_I
//   and TGA_I. Load wcnt = WAIT_STATES. Go to WAIT, or to RESP if
//   WAIT_STATES = 0.
// - WAIT: if CYC_I=0 or STB_I=0, abort: go to IDLE with no response and
//   no write. Otherwise decrement wcnt. When wcnt reaches 1, go to RESP and
//   register the termination in the same edge.
// - RESP: exactly one of ACK_O, ERR_O or RTY_O is high for exactly one
//   cycle. Next state is IDLE unconditionally, so a request is never
//   double-acked.
// Latency:
// - Request sampled at edge N; termination is high during cycle
//   N+1+WAIT_STATES.
// - The earliest next request is sampled at edge N+2+WAIT_STATES.
// Termination priority, decided at the RESP-entry edge:
// - ERR when ADR_I[63:3] >= DEPTH. ERR never writes; DAT_O = 0.
// - Else RTY when RTY_EVERY != 0 and this is the RTY_EVERY-th
//   in-range request since the last RTY or reset. RTY has no side effect.
// - Else ACK. On a write, commit only the lanes with SEL_I[k]=1 at this
//   edge. On a read, DAT_O = mem[idx] with all 8 lanes returned
//   regardless of SEL_I.
// Retry counter:
// - Counts in-range requests that reach RESP. Aborted and ERR requests do
//   not count.
// - Wraps to 0 when RTY is issued.
// Reset mid-operation: an outstanding request is dropped with no write
// and no termination.
// Same-edge events: a request present on the RESP->IDLE edge is not
// sampled. The master must hold STB_I until it sees a termination.
// TESTING
// 1. Write 0xDEADBEEF_CAFEF00D to 0x10 with SEL=0xFF, WAIT_STATES=1, then
//    read 0x10 -> ACK in cycle N+2, DAT_O=0xDEADBEEF_CAFEF00D, TGD_O=TGA_I.
// 2. Preload 0x10 with 0; write 0xFFFF_FFFF_FFFF_FFFF with SEL=0x0F, then
//    read -> 0x00000000_FFFFFFFF.
// 3. Read at ADR_I = DEPTH*8 -> ERR_O pulse, ACK_O=0, memory unchanged;
//    then a read at 0x0 -> normal ACK.
// 4. RTY_EVERY=3, six back-to-back reads -> responses ACK, ACK, RTY, ACK,
//    ACK, RTY.
// 5. WAIT_STATES=4, drop STB_I after 2 cycles of a write -> no
//    termination, no write; next read returns the old data.
// 6. Assert rst during WAIT of a write -> all outputs 0 asynchronously, no
//    write; after release a read returns the pre-reset data with ACK.

Source files
------------

// File: rtl/wb_slave_mem.sv
// wb_slave_mem: Wishbone classic (B3) 64-bit slave memory. It supports
// byte-lane writes, a fixed number of wait states, ERR on words beyond DEPTH
// and deterministic RTY on every RTY_EVERY-th in-range request.
module wb_slave_mem #(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1,
   parameter int RTY_EVERY   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] ADR_I,
   input  logic [63:0] DAT_I,
   input  logic [7:0]  SEL_I,
   input  logic        CYC_I,
   input  logic        STB_I,
   input  logic        WE_I,
   input  logic        LOCK_I,
   input  logic [15:0] TGA_I,
   input  logic [15:0] TGD_I,
   output logic [63:0] DAT_O,
   output logic [15:0] TGD_O,
   output logic        ACK_O,
   output logic        ERR_O,
   output logic        RTY_O
);

   localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            RW        = (RTY_EVERY > 1) ? $clog2(RTY_EVERY) : 1;
   localparam logic [3:0]    WAIT_INIT = 4'(WAIT_STATES);
   localparam logic [RW-1:0] RTY_LAST  = RW'(RTY_EVERY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    wcnt, wcnt_nxt;
   logic [RW-1:0] rcnt;

   // Request captured at the sample edge, used while waiting.
   logic [60:0]   adr_q;
   logic          we_q;
   logic [7:0]    sel_q;
   logic [63:0]   dat_q;
   logic [15:0]   tga_q;

   logic [63:0]   mem [DEPTH];

   logic          req;
   logic          enter_resp;
   logic [60:0]   cur_adr;
   logic          cur_we;
   logic [7:0]    cur_sel;
   logic [63:0]   cur_dat;
   logic [15:0]   cur_tga;
   logic [AW-1:0] idx;
   logic          in_range, rty_hit;
   logic          do_ack, do_err, do_rty;

   // Byte offset, lock and data tag carry no meaning for this slave.
   logic          unused;
   assign unused = ^{ADR_I[2:0], LOCK_I, TGD_I};

   assign req = CYC_I & STB_I;

   // Fields of the request being decided: live bus when answering straight
   // from IDLE (no wait states), captured copy once the request is waiting.
   always_comb begin
      if (state == IDLE) begin
         cur_adr = ADR_I[63:3];
         cur_we  = WE_I;
         cur_sel = SEL_I;
         cur_dat = DAT_I;
         cur_tga = TGA_I;
      end else begin
         cur_adr = adr_q;
         cur_we  = we_q;
         cur_sel = sel_q;
         cur_dat = dat_q;
         cur_tga = tga_q;
      end
   end

   // Next-state logic: sample in IDLE, count down in WAIT, single-cycle RESP.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_nxt  = state;
      wcnt_nxt   = wcnt;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               wcnt_nxt = WAIT_INIT;
               if (WAIT_STATES == 0) begin
                  state_nxt  = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (!req) begin
               state_nxt = IDLE;
            end else if (wcnt == 4'd1) begin
               state_nxt  = RESP;
               enter_resp = 1'b1;
            end else begin
               wcnt_nxt = wcnt - 4'd1;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Termination decision on the RESP-entry edge: ERR beats RTY beats ACK.
   always_comb begin
      idx      = cur_adr[AW-1:0];
      in_range = cur_adr < 61'(DEPTH);
      rty_hit  = (RTY_EVERY != 0) && (rcnt == RTY_LAST);
      do_err   = enter_resp && !in_range;
      do_rty   = enter_resp && in_range && rty_hit;
      do_ack   = enter_resp && in_range && !rty_hit;
   end

   // Control state, request capture, retry counter and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         wcnt  <= '0;
         rcnt  <= '0;
         adr_q <= '0;
         we_q  <= 1'b0;
         sel_q <= '0;
         dat_q <= '0;
         tga_q <= '0;
         ACK_O <= 1'b0;
         ERR_O <= 1'b0;
         RTY_O <= 1'b0;
         DAT_O <= '0;
         TGD_O <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register sees pre-edge values, independent of statement order.
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
         if (state == IDLE && req) begin
            adr_q <= ADR_I[63:3];
            we_q  <= WE_I;
            sel_q <= SEL_I;
            dat_q <= DAT_I;
            tga_q <= TGA_I;
         end
         ACK_O <= do_ack;
         ERR_O <= do_err;
         RTY_O <= do_rty;
         DAT_O <= (do_ack && !cur_we) ? mem[idx] : '0;
         TGD_O <= do_ack ? cur_tga : '0;
         if (do_rty) begin
            rcnt <= '0;
         end else if (do_ack && (RTY_EVERY != 0)) begin
            rcnt <= rcnt + RW'(1);
         end
      end
   end

   // Byte-lane commit on the ACK edge of a write. A request racing an
   // asserted reset must never land, hence the rst qualifier.
   // NOTE: the array has no reset; contents survive rst by design and a
   // reset loop over DEPTH words would not map onto a RAM.
   always_ff @(posedge clk) begin
      if (rst && do_ack && cur_we) begin
         for (int k = 0; k < 8; k++) begin
            if (cur_sel[k]) begin
               mem[idx][8*k +: 8] <= cur_dat[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_slave_mem.sv
// tb_wb_slave_mem: directed bench for wb_slave_mem with a transaction-level
// model (word array + retry count + due-cycle queue) checked every cycle.
module tb_wb_slave_mem;

   localparam int DEPTH = 256;
   localparam int WS    = 3;
   localparam int RTY_N = 3;

   typedef enum logic [1:0] {T_NONE, T_ACK, T_ERR, T_RTY} term_e;

   typedef struct {
      int          due;
      term_e       kind;
      logic [63:0] dat;
      logic [15:0] tgd;
      bit          chk_dat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] ADR_I = '0;
   logic [63:0] DAT_I = '0;
   logic [7:0]  SEL_I = '0;
   logic        CYC_I = 1'b0;
   logic        STB_I = 1'b0;
   logic        WE_I = 1'b0;
   logic        LOCK_I = 1'b0;
   logic [15:0] TGA_I = '0;
   logic [15:0] TGD_I = '0;
   logic [63:0] DAT_O;
   logic [15:0] TGD_O;
   logic        ACK_O, ERR_O, RTY_O;

   wb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(WS), .RTY_EVERY(RTY_N)) dut (
      .clk(clk), .rst(rst), .ADR_I(ADR_I), .DAT_I(DAT_I), .SEL_I(SEL_I),
      .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I), .LOCK_I(LOCK_I),
      .TGA_I(TGA_I), .TGD_I(TGD_I), .DAT_O(DAT_O), .TGD_O(TGD_O),
      .ACK_O(ACK_O), .ERR_O(ERR_O), .RTY_O(RTY_O)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_pass   = 0;
   exp_t        exp_q[$];
   logic [63:0] model_mem [DEPTH];
   int          rty_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
   endtask

   // Transaction-level model: range test, retry rule, byte-lane memory.
   task automatic predict(input logic we, input logic [63:0] adr, input logic [63:0] dat,
                          input logic [7:0] sel, output term_e kind, output logic [63:0] rdat);
      logic [60:0] widx;
      widx = adr[63:3];
      rdat = '0;
      if (widx >= 61'(DEPTH)) begin
         kind = T_ERR;
      end else begin
         rty_cnt++;
         if (RTY_N != 0 && rty_cnt == RTY_N) begin
            kind    = T_RTY;
            rty_cnt = 0;
         end else begin
            kind = T_ACK;
            if (we) begin
               for (int k = 0; k < 8; k++)
                  if (sel[k]) model_mem[int'(widx)][8*k +: 8] = dat[8*k +: 8];
            end else begin
               rdat = model_mem[int'(widx)];
            end
         end
      end
   endtask

   // Compare process: outputs equal the due expectation, else all zero.
   always @(negedge clk) begin
      term_e       k;
      logic [63:0] d;
      logic [15:0] t;
      bit          cd;
      k = T_NONE; d = '0; t = '0; cd = 1'b1;
      if (rst && exp_q.size() > 0 && exp_q[0].due == cyc) begin
         k  = exp_q[0].kind;
         d  = exp_q[0].dat;
         t  = exp_q[0].tgd;
         cd = exp_q[0].chk_dat;
         void'(exp_q.pop_front());
      end
      check("term {ack,err,rty}", 64'({ACK_O, ERR_O, RTY_O}),
            64'({k == T_ACK, k == T_ERR, k == T_RTY}));
      if (cd) check("dat_o", DAT_O, d);
      check("tgd_o", 64'(TGD_O), 64'(t));
   end

   task automatic idle(input int n);
      CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called 1 ns after a rising edge; reset lands mid-cycle.
   task automatic do_reset();
      CYC_I = 1'b0; STB_I = 1'b0;
      #2 rst = 1'b0;
      #1 check("async clear", 64'({ACK_O, ERR_O, RTY_O, |DAT_O, |TGD_O}), 64'd0);
      exp_q.delete();
      rty_cnt = 0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic drive(input logic we, input logic [63:0] adr, input logic [63:0] dat,
                        input logic [7:0] sel, input logic [15:0] tga);
      CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat;
      SEL_I = sel; TGA_I = tga;
      LOCK_I = 1'($urandom_range(0, 1));
      TGD_I  = 16'($urandom);
   endtask

   task automatic expect_req(input logic we, input logic [63:0] adr, input logic [63:0] dat,
                             input logic [7:0] sel, input logic [15:0] tga,
                             output term_e kind, output logic [63:0] rdat);
      exp_t e;
      predict(we, adr, dat, sel, kind, rdat);
      e.due     = cyc + 1 + WS;
      e.kind    = kind;
      e.dat     = rdat;
      e.tgd     = (kind == T_ACK) ? tga : 16'h0;
      e.chk_dat = !(kind == T_ACK && we);
      exp_q.push_back(e);
   endtask

   // One full transaction; returns 1 ns after the RESP->IDLE edge with the
   // request still driven, so a following call is back-to-back.
   task automatic xfer(input logic we, input logic [63:0] adr, input logic [63:0] dat,
                       input logic [7:0] sel, input logic [15:0] tga,
                       output term_e kind, output logic [63:0] rdat);
      drive(we, adr, dat, sel, tga);
      expect_req(we, adr, dat, sel, tga, kind, rdat);
      repeat (WS + 2) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      term_e       k;
      logic [63:0] r;
      term_e       b2b [6];
      b2b = '{T_ACK, T_ACK, T_RTY, T_ACK, T_ACK, T_RTY};

      repeat (2) @(posedge clk);
      #1;
      check("reset outputs", 64'({ACK_O, ERR_O, RTY_O, |DAT_O, |TGD_O}), 64'd0);
      rst = 1'b1;

      // Full-word write then read-back with tag echo.
      xfer(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 16'h1111, k, r);
      check("pin write ack", 64'(k), 64'(T_ACK));
      xfer(1'b0, 64'h10, 64'h0, 8'hFF, 16'hA5C3, k, r);
      check("pin read data", r, 64'hDEADBEEF_CAFEF00D);
      idle(2);

      // Low-lane write over zero; read after a reset keeps memory.
      do_reset();
      xfer(1'b1, 64'h10, 64'h0, 8'hFF, 16'h0002, k, r);
      xfer(1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 16'h0003, k, r);
      idle(1);
      do_reset();
      xfer(1'b0, 64'h10, 64'h0, 8'h01, 16'h0004, k, r);
      check("pin partial write", r, 64'h00000000_FFFFFFFF);
      idle(1);

      // Out-of-range reads/writes, boundary word, ERR does not count.
      do_reset();
      xfer(1'b0, 64'(DEPTH * 8), 64'h0, 8'hFF, 16'h0005, k, r);
      check("pin err at DEPTH*8", 64'(k), 64'(T_ERR));
      xfer(1'b1, 64'h810, 64'h1111_2222_3333_4444, 8'hFF, 16'h0006, k, r);
      check("pin err write", 64'(k), 64'(T_ERR));
      xfer(1'b0, 64'h10, 64'h0, 8'hFF, 16'h0007, k, r);
      check("pin no err write", r, 64'h00000000_FFFFFFFF);
      xfer(1'b1, 64'h7F8, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 16'h0008, k, r);
      xfer(1'b0, 64'h8000_0000_0000_0010, 64'h0, 8'hFF, 16'h0009, k, r);
      check("pin err high addr", 64'(k), 64'(T_ERR));
      xfer(1'b0, 64'h7F8, 64'h0, 8'hFF, 16'h000A, k, r);
      check("pin third in-range rty", 64'(k), 64'(T_RTY));
      xfer(1'b0, 64'h7FD, 64'h0, 8'h00, 16'h000B, k, r);
      check("pin last word", r, 64'hA5A5_5A5A_0F0F_F0F0);
      idle(1);

      // Six back-to-back reads: ACK ACK RTY ACK ACK RTY.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         xfer(1'b0, 64'h10, 64'h0, 8'hFF, 16'(16'h0100 + i), k, r);
         check($sformatf("pin b2b kind %0d", i), 64'(k), 64'(b2b[i]));
      end
      idle(1);

      // Abort in WAIT: no termination, no write, not counted.
      do_reset();
      drive(1'b1, 64'h10, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 16'h0200);
      repeat (2) @(posedge clk);
      #1;
      STB_I = 1'b0;
      repeat (WS + 3) @(posedge clk);
      #1;
      idle(1);
      xfer(1'b0, 64'h10, 64'h0, 8'hFF, 16'h0201, k, r);
      check("pin after abort", r, 64'h00000000_FFFFFFFF);
      xfer(1'b0, 64'h10, 64'h0, 8'hFF, 16'h0202, k, r);
      xfer(1'b0, 64'h10, 64'h0, 8'hFF, 16'h0203, k, r);
      check("pin abort not counted", 64'(k), 64'(T_RTY));
      idle(1);

      // Reset during WAIT of a write, then during the ACK cycle of a read.
      do_reset();
      drive(1'b1, 64'h10, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 16'h0300);
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      xfer(1'b0, 64'h10, 64'h0, 8'hFF, 16'h0301, k, r);
      check("pin after wait reset", r, 64'h00000000_FFFFFFFF);
      idle(1);
      drive(1'b0, 64'h7F8, 64'h0, 8'hFF, 16'h0302);
      expect_req(1'b0, 64'h7F8, 64'h0, 8'hFF, 16'h0302, k, r);
      repeat (WS + 1) @(posedge clk);
      #1;
      check("ack before reset", 64'(ACK_O), 64'd1);
      do_reset();
      xfer(1'b0, 64'h7F8, 64'h0, 8'hFF, 16'h0303, k, r);
      check("pin after resp reset", r, 64'hA5A5_5A5A_0F0F_F0F0);
      idle(4);

      check("queue drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
